// File: rtl/cache_arb_pkg.sv
// Shared definitions for the cache port arbiter.
//   - arb_state_t : arbiter FSM states
//   - ADDR_W_DEF / DATA_W_DEF : default address and data widths
//   - PORT_IFETCH / PORT_DATA : requester port indices
//   - port_onehot() : converts a port index into a 2-bit one-hot strobe
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 64;

    localparam logic [0:0] PORT_IFETCH = 1'b0;
    localparam logic [0:0] PORT_DATA   = 1'b1;

    // One-hot strobe for a single port index.
    function automatic logic [1:0] port_onehot(input logic [0:0] idx);
        logic [1:0] oh;
        if (idx == PORT_IFETCH) begin
            oh = 2'b01;
        end else begin
            oh = 2'b10;
        end
        return oh;
    endfunction

endpackage

// File: rtl/cache_rr_pick.sv
// Combinational two-way round-robin pick.
//   req_valid  in  2  request valid per port
//   last_gnt   in  1  index of the port granted most recently
//   gnt        out 2  one-hot grant (all zero when nothing is requesting)
// On a tie the port that did NOT win last time is picked.
module cache_rr_pick
    import cache_arb_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    // Grant selection: sole requester wins, tie goes to the other port.
    always_comb begin
        gnt = 2'b00;
        case (req_valid)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                if (last_gnt == PORT_DATA) begin
                    gnt = 2'b01;
                end else begin
                    gnt = 2'b10;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares the single-ported cache between instruction fetch (port 0) and
// data load/store (port 1). One transaction in flight at a time.
//   clk, rst_b         clock / asynchronous active-low reset
//   req_valid/ready    per-port handshake; ready only asserted in IDLE
//   req_wr/addr/wdata  per-port request payload (port i at slice i)
//   resp_valid         one-cycle strobe on the winning port only
//   resp_err/rdata     response payload, qualified by resp_valid
//   c_en               one-cycle cache enable pulse
//   c_wr/addr/wdata    registered cache command, held until next accept
//   c_done/c_rdata     cache completion pulse and read data
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_wr,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          resp_valid,
    output logic                resp_err,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                c_en,
    output logic                c_wr,
    output logic [ADDR_W-1:0]   c_addr,
    output logic [DATA_W-1:0]   c_wdata,
    input  logic                c_done,
    input  logic [DATA_W-1:0]   c_rdata
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t          state_r;
    arb_state_t          state_nxt_s;
    logic                last_gnt_r;
    logic                win_r;
    logic                win_s;
    logic [1:0]          gnt_s;
    logic                accept_s;
    logic                done_ok_s;
    logic                timeout_s;
    logic [CNT_W-1:0]    cnt_r;

    logic                c_en_r;
    logic                c_wr_r;
    logic [ADDR_W-1:0]   c_addr_r;
    logic [DATA_W-1:0]   c_wdata_r;
    logic [1:0]          resp_valid_r;
    logic                resp_err_r;
    logic [DATA_W-1:0]   resp_rdata_r;

    cache_rr_pick u_pick (
        .req_valid (req_valid),
        .last_gnt  (last_gnt_r),
        .gnt       (gnt_s)
    );

    assign win_s     = gnt_s[PORT_DATA];
    assign req_ready = (state_r == ST_IDLE) ? gnt_s : 2'b00;

    // Next-state logic and per-state event decode.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        done_ok_s   = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((req_valid & gnt_s) != 2'b00) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            // c_done is deliberately not looked at here.
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                // Completion takes priority over a coinciding timeout.
                if (c_done) begin
                    done_ok_s   = 1'b1;
                    state_nxt_s = ST_RESP;
                end else if (cnt_r == CNT_LAST) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Cache command latch: captured on accept, held until the next accept.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            c_wr_r    <= 1'b0;
            c_addr_r  <= {ADDR_W{1'b0}};
            c_wdata_r <= {DATA_W{1'b0}};
            win_r     <= 1'b0;
        end else if (accept_s) begin
            c_wr_r    <= req_wr[win_s];
            c_addr_r  <= win_s ? req_addr[2*ADDR_W-1:ADDR_W]
                               : req_addr[ADDR_W-1:0];
            c_wdata_r <= win_s ? req_wdata[2*DATA_W-1:DATA_W]
                               : req_wdata[DATA_W-1:0];
            win_r     <= win_s;
        end
    end

    // Cache enable: registered so it is high exactly during ISSUE.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            c_en_r <= 1'b0;
        end else begin
            c_en_r <= accept_s;
        end
    end

    // Timeout counter: cleared in ISSUE, counts WAIT cycles, never wraps
    // because WAIT is left on the terminal count.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_ISSUE) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_WAIT) && !done_ok_s && !timeout_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Response registers: loaded on WAIT exit so they are valid during RESP,
    // zero in every other state. Writes and timeouts return zero data.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            resp_valid_r <= 2'b00;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= {DATA_W{1'b0}};
        end else if (done_ok_s || timeout_s) begin
            resp_valid_r <= port_onehot(win_r);
            resp_err_r   <= timeout_s;
            resp_rdata_r <= (done_ok_s && !c_wr_r) ? c_rdata : {DATA_W{1'b0}};
        end else begin
            resp_valid_r <= 2'b00;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= {DATA_W{1'b0}};
        end
    end

    // Round-robin history: updated once the response has been delivered.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            last_gnt_r <= PORT_DATA;
        end else if (state_r == ST_RESP) begin
            last_gnt_r <= win_r;
        end
    end

    assign c_en       = c_en_r;
    assign c_wr       = c_wr_r;
    assign c_addr     = c_addr_r;
    assign c_wdata    = c_wdata_r;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;

endmodule
